lut_weight_reader: RTL and testbench

Reads packed weight words from the 256-bit weight LUT and delivers them to the layer-1 MAC array as a stream of 16-bit signed weights with valid/ready backpressure. On `start` it walks LUT addresses `BASE_ADDR, BASE_ADDR+ADDR_STEP, …` for `NUM_WORDS` words. It accounts for the LUT's one-cycle registered read latency and unpacks each word most-significant lane first. It sits between the LUT and the weight-load port of the convolution datapath.

---
 rtl/lut_weight_reader_if.sv | 24 ++
 rtl/lut_weight_reader.sv | 103 ++++++++++
 tb/tb_lut_weight_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_weight_reader_if.sv
// Weight stream from the LUT reader to the MAC array weight-load port.
// w_valid rises only with a lane ready to go, holds w_data/w_last until a w_valid && w_ready edge.
interface lut_weight_reader_if #(
    parameter int LANE_W = 16
);
    logic [LANE_W-1:0] w_data;
    logic              w_valid;
    logic              w_ready;
    logic              w_last;

    modport master (
        output w_data,
        output w_valid,
        output w_last,
        input  w_ready
    );

    modport slave (
        input  w_data,
        input  w_valid,
        input  w_last,
        output w_ready
    );
endinterface

// File: rtl/lut_weight_reader.sv
// Walks the weight LUT one packed word at a time and streams each word out as
// signed lanes, most-significant lane first, under valid/ready backpressure.
module lut_weight_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_W     = 256,
    parameter int LANE_W     = 16,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_STEP  = 16,
    parameter int NUM_WORDS  = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_lut_addr,
    input  logic [WORD_W-1:0]     i_lut_data,
    lut_weight_reader_if.master   w_if,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_state
);
    localparam int LANES  = WORD_W / LANE_W;
    localparam int WCNT_W = $clog2(NUM_WORDS) + 1;
    localparam int LCNT_W = $clog2(LANES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_STREAM = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_lut_addr;
    logic [WCNT_W-1:0]     r_word_cnt;
    logic [LCNT_W-1:0]     r_lane_cnt;
    logic [WORD_W-1:0]     r_shift;
    logic                  r_done;

    logic w_hs;
    logic w_last_lane;
    logic w_last_word;

    assign w_hs        = (r_state == S_STREAM) && w_if.w_ready;
    assign w_last_lane = (r_lane_cnt == LCNT_W'(LANES - 1));
    assign w_last_word = (r_word_cnt == WCNT_W'(NUM_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_lut_addr <= '0;
            r_word_cnt <= '0;
            r_lane_cnt <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_ISSUE;
                        r_lut_addr <= ADDR_WIDTH'(BASE_ADDR);
                        r_word_cnt <= '0;
                    end
                end
                // Address is held here; the LUT registers it at the end of this cycle.
                S_ISSUE: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift    <= i_lut_data;
                    r_lane_cnt <= '0;
                    r_state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        r_shift    <= r_shift << LANE_W;
                        r_lane_cnt <= r_lane_cnt + 1'b1;
                        if (w_last_lane) begin
                            if (w_last_word) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                                r_lut_addr <= r_lut_addr + ADDR_WIDTH'(ADDR_STEP);
                                r_state    <= S_ISSUE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_if.w_data  = r_shift[WORD_W-1 -: LANE_W];
    assign w_if.w_valid = (r_state == S_STREAM);
    assign w_if.w_last  = (r_state == S_STREAM) && w_last_lane && w_last_word;

    assign o_lut_addr = r_lut_addr;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_state    = r_state;
endmodule

// File: tb/tb_lut_weight_reader.sv
// Bench for lut_weight_reader: a registered LUT model, a lane-queue reference
// model checked every cycle, plus literal checks on known LUT contents.
module tb_lut_weight_reader;
    localparam int NW    = 28;
    localparam int LANES = 16;
    localparam int PASS  = NW * LANES;
    localparam int BASE  = 0;
    localparam int STEP  = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic         start1;
    logic [31:0]  lut_addr;
    logic [31:0]  lut_addr1;
    logic [255:0] lut_data;
    logic [255:0] lut_data1;
    logic         busy, done, busy1, done1;
    logic [1:0]   state, state1;

    lut_weight_reader_if #(.LANE_W(16)) wif ();
    lut_weight_reader_if #(.LANE_W(16)) wif1 ();

    lut_weight_reader dut (
        .clk(clk), .rst(rst), .i_start(start), .o_lut_addr(lut_addr),
        .i_lut_data(lut_data), .w_if(wif), .o_busy(busy), .o_done(done), .o_state(state)
    );

    lut_weight_reader #(.NUM_WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .o_lut_addr(lut_addr1),
        .i_lut_data(lut_data1), .w_if(wif1), .o_busy(busy1), .o_done(done1), .o_state(state1)
    );

    // ---------------- clock / LUT model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [255:0] lut_mem [32];

    function automatic logic [255:0] lut_read(input logic [31:0] a);
        if (a[3:0] == 4'd0 && a < 32'd512) return lut_mem[a[8:4]];
        return {8{32'hDEADBEEF}};
    endfunction

    always @(posedge clk) begin
        lut_data  <= lut_read(lut_addr);
        lut_data1 <= lut_read(lut_addr1);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [15:0] exp_q[$];
    bit          chk_en = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_gap  = 0;
    bit          exp_valid;
    int          lane_idx;

    task automatic load_model();
        logic [255:0] w;
        exp_q.delete();
        for (int wi = 0; wi < NW; wi++) begin
            w = lut_mem[wi];
            for (int l = 0; l < LANES; l++) exp_q.push_back(w[255 - 16*l -: 16]);
        end
    endtask

    // Reference: a pass is the flat list of lanes; valid after a 2-cycle gap
    // following start and following each word's last lane.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_valid = m_busy && (m_gap == 0);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("valid", 32'(wif.w_valid), 32'(exp_valid));
            chk("done", 32'(done), 32'(m_done));
            if (exp_valid) begin
                chk("data", 32'(wif.w_data), 32'(exp_q[0]));
                chk("last", 32'(wif.w_last), 32'(exp_q.size() == 1));
            end else begin
                chk("last_idle", 32'(wif.w_last), 32'd0);
            end
            if (m_busy && exp_q.size() > 0)
                chk("lut_addr", lut_addr, 32'(BASE + STEP * ((PASS - exp_q.size()) / LANES)));
            m_done = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
                m_gap  = 0;
                exp_q.delete();
            end else if (m_busy) begin
                if (m_gap > 0) begin
                    m_gap--;
                end else if (wif.w_ready) begin
                    lane_idx = PASS - exp_q.size();
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end else if (lane_idx % LANES == LANES - 1) begin
                        m_gap = 2;
                    end
                end
            end else if (start) begin
                load_model();
                m_busy = 1'b1;
                m_gap  = 2;
            end
        end
    end

    // Handshake recorder used by the directed literal checks.
    logic [15:0] got[$];
    logic        got_last[$];
    logic [31:0] got_addr[$];
    int          got_t[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (!rst && wif.w_valid && wif.w_ready) begin
            got.push_back(wif.w_data);
            got_last.push_back(wif.w_last);
            got_addr.push_back(lut_addr);
            got_t.push_back(cyc);
        end
        if (done) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    int rdy_mode = 0;
    int st_t;

    initial begin
        wif.w_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wif.w_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic clear_rec();
        got.delete();
        got_last.delete();
        got_addr.delete();
        got_t.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        st_t = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic init_lut();
        logic [255:0] w;
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
            lut_mem[i] = w;
        end
        w = lut_mem[0];
        w[255:240] = 16'h0049;
        w[239:224] = 16'hF207;
        w[223:208] = 16'h03DA;
        w[15:0]    = 16'h030F;
        lut_mem[0] = w;
        w = lut_mem[1];
        w[255:240] = 16'h0199;
        lut_mem[1] = w;
        w = lut_mem[27];
        w[255:240] = 16'hFFA2;
        w[15:0]    = 16'h0007;
        lut_mem[27] = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [15:0] ref_q[$];
    int d0, diff, n, hs1, last_cnt1, last_n1, last_t1, done_t1, done_n1, addr_bad1, st1;
    logic [15:0] last_d1;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        wif1.w_ready = 1'b1;
        init_lut();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(wif.w_valid), 32'd0);
        chk("rst_addr", lut_addr, 32'd0);
        chk("rst_data", 32'(wif.w_data), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk_en = 1'b1;

        // Full pass, always ready.
        clear_rec();
        d0 = done_cnt;
        pulse_start();
        wait_done(700);
        chk("t1_count", 32'(got.size()), 32'(PASS));
        if (got.size() == PASS) begin
            chk("t1_w0l0", 32'(got[0]), 32'h0049);
            chk("t1_w0l1", 32'(got[1]), 32'hF207);
            chk("t1_w0l2", 32'(got[2]), 32'h03DA);
            chk("t1_w0l15", 32'(got[15]), 32'h030F);
            chk("t1_w1l0", 32'(got[16]), 32'h0199);
            chk("t1_bubble", 32'(got_t[16] - got_t[15]), 32'd3);
            chk("t1_first_lat", 32'(got_t[0] - st_t), 32'd3);
            chk("t1_addr_w1", got_addr[16], 32'd16);
            chk("t1_addr_w27", got_addr[447], 32'd432);
            chk("t1_w27l0", 32'(got[432]), 32'hFFA2);
            chk("t1_final", 32'(got[447]), 32'h0007);
            chk("t1_final_last", 32'(got_last[447]), 32'd1);
            chk("t1_prev_last", 32'(got_last[446]), 32'd0);
            chk("t1_cycles", 32'(got_t[447] - st_t), 32'd504);
        end
        chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
        ref_q = got;

        // Random backpressure: same lane sequence.
        rdy_mode = 1;
        clear_rec();
        pulse_start();
        wait_done(4000);
        diff = 0;
        foreach (got[i]) if (i < ref_q.size() && got[i] !== ref_q[i]) diff++;
        chk("t2_count", 32'(got.size()), 32'(PASS));
        chk("t2_seq_diff", 32'(diff), 32'd0);

        // Start hammered while busy.
        d0 = done_cnt;
        clear_rec();
        @(posedge clk);
        #1 start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1 start = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        wait_done(4000);
        chk("t3_count", 32'(got.size()), 32'(PASS));
        chk("t3_done_once", 32'(done_cnt - d0), 32'd1);

        // Reset at word 5, lane 7.
        rdy_mode = 0;
        clear_rec();
        pulse_start();
        n = 0;
        while (got.size() < 87 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_reach", 32'(got.size()), 32'd87);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_valid", 32'(wif.w_valid), 32'd0);
        chk("t4_last", 32'(wif.w_last), 32'd0);
        chk("t4_data", 32'(wif.w_data), 32'd0);
        chk("t4_addr", lut_addr, 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        clear_rec();
        pulse_start();
        wait_done(700);
        chk("t4_restart_n", 32'(got.size()), 32'(PASS));
        if (got.size() > 0) begin
            chk("t4_restart_l0", 32'(got[0]), 32'h0049);
            chk("t4_restart_addr", got_addr[0], 32'd0);
        end

        // Single-word pass on the NUM_WORDS=1 instance.
        hs1 = 0; last_cnt1 = 0; last_n1 = 0; last_t1 = 0; done_t1 = 0; done_n1 = 0; addr_bad1 = 0;
        last_d1 = '0;
        @(posedge clk);
        #1 start1 = 1'b1;
        @(negedge clk);
        st1 = cyc;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) begin
                @(posedge clk);
                #1 start1 = 1'b0;
            end
            @(negedge clk);
            if (wif1.w_valid && wif1.w_ready) begin
                hs1++;
                if (wif1.w_last) begin
                    last_cnt1++;
                    last_n1 = hs1;
                    last_t1 = cyc;
                    last_d1 = wif1.w_data;
                end
            end
            if (done1) begin
                done_n1++;
                done_t1 = cyc;
            end
            if (lut_addr1 != 32'd0) addr_bad1++;
        end
        chk("b_handshakes", 32'(hs1), 32'd16);
        chk("b_last_count", 32'(last_cnt1), 32'd1);
        chk("b_last_pos", 32'(last_n1), 32'd16);
        chk("b_last_data", 32'(last_d1), 32'h030F);
        chk("b_last_time", 32'(last_t1 - st1), 32'd18);
        // done rises on the 18th edge after the start edge, seen the half-cycle after.
        chk("b_done_time", 32'(done_t1 - st1), 32'd19);
        chk("b_done_once", 32'(done_n1), 32'd1);
        chk("b_addr_const", 32'(addr_bad1), 32'd0);
        chk("b_idle", 32'(busy1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
